// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: sequences IF/ID/EX/MEM/WB over a shared
// memory port and drives datapath selects, write enables and the ALU operation.
module multicycle_ctrl #(
    parameter int unsigned ALU_W       = 3,
    parameter int unsigned RESET_STATE = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [ALU_W-1:0] alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_LW, C_SW, C_ADDIU, C_BEQ, C_BNE, C_J, C_ILL
    } class_t;

    state_t     cur;
    class_t     cls;
    class_t     op_cls;
    logic [2:0] r_op;
    logic       r_ok;

    always_comb begin
        case (opcode)
            6'b000000: op_cls = C_RTYPE;
            6'b100011: op_cls = C_LW;
            6'b101011: op_cls = C_SW;
            6'b001001: op_cls = C_ADDIU;
            6'b000100: op_cls = C_BEQ;
            6'b000101: op_cls = C_BNE;
            6'b000010: op_cls = C_J;
            default:   op_cls = C_ILL;
        endcase
    end

    always_comb begin
        r_ok = 1'b1;
        case (funct)
            6'b100001: r_op = 3'b010;
            6'b100011: r_op = 3'b110;
            6'b100100: r_op = 3'b000;
            6'b100101: r_op = 3'b001;
            6'b101010: r_op = 3'b111;
            default: begin
                r_op = 3'b000;
                r_ok = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur     <= state_t'(RESET_STATE[2:0]);
            cls     <= C_RTYPE;
            illegal <= 1'b0;
        end else begin
            case (cur)
                S_IF: if (mem_ready) cur <= S_ID;
                S_ID: begin
                    cls <= op_cls;
                    case (op_cls)
                        C_J:     cur <= S_IF;
                        C_ILL: begin
                            illegal <= 1'b1;
                            cur     <= S_HALT;
                        end
                        default: cur <= S_EX;
                    endcase
                end
                S_EX: begin
                    case (cls)
                        C_RTYPE: begin
                            if (r_ok) begin
                                cur <= S_WB;
                            end else begin
                                illegal <= 1'b1;
                                cur     <= S_HALT;
                            end
                        end
                        C_LW, C_SW: cur <= S_MEM;
                        C_ADDIU:    cur <= S_WB;
                        default:    cur <= S_IF;
                    endcase
                end
                S_MEM:   if (mem_ready) cur <= (cls == C_SW) ? S_IF : S_WB;
                S_WB:    cur <= S_IF;
                S_HALT:  cur <= S_HALT;
                default: cur <= S_IF;
            endcase
        end
    end

    // Decoded outputs are gated by resetn so every enable drops the instant reset asserts.
    always_comb begin
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = '0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        if (resetn) begin
            case (cur)
                S_IF: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = ALU_W'(3'b010);
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_ID: begin
                    alu_src_b = 2'b11;
                    alu_op    = ALU_W'(3'b010);
                    if (op_cls == C_J) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                    end
                end
                S_EX: begin
                    alu_src_a = 1'b1;
                    case (cls)
                        C_RTYPE: alu_op = ALU_W'(r_op);
                        C_LW, C_SW, C_ADDIU: begin
                            alu_src_b = 2'b10;
                            alu_op    = ALU_W'(3'b010);
                        end
                        C_BEQ, C_BNE: begin
                            alu_op   = ALU_W'(3'b110);
                            pc_src   = 2'b01;
                            pc_write = (cls == C_BEQ) ? zero : ~zero;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_wr  = (cls == C_SW);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (cls == C_RTYPE);
                    mem_to_reg = (cls == C_LW);
                end
                default: ;
            endcase
        end
    end

    assign state = cur;

endmodule
